// File: rtl/hardwired_control_unit.sv
// Multi-cycle hardwired controller for the ALU/register-file datapath.
// Sequences FETCH_L -> FETCH_H -> EXEC0 [-> SRC1] [-> SRC2] [-> EXEC_ALU] and drives every datapath control.
module hardwired_control_unit (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] IR_Value,
  input  logic [3:0]  Flags,
  output logic [2:0]  RF_OutASel,
  output logic [2:0]  RF_OutBSel,
  output logic [2:0]  RF_FunSel,
  output logic [3:0]  RF_RegSel,
  output logic [3:0]  RF_ScrSel,
  output logic [4:0]  ALU_FunSel,
  output logic        ALU_WF,
  output logic [1:0]  ARF_OutCSel,
  output logic [1:0]  ARF_OutDSel,
  output logic [2:0]  ARF_FunSel,
  output logic [2:0]  ARF_RegSel,
  output logic        IR_LH,
  output logic        IR_Write,
  output logic        Mem_WR,
  output logic        Mem_CS,
  output logic [1:0]  MuxASel,
  output logic [1:0]  MuxBSel,
  output logic        MuxCSel,
  output logic [2:0]  T,
  output logic        Halted
);

  typedef enum logic [2:0] {
    S_FETCH_L  = 3'd0,
    S_FETCH_H  = 3'd1,
    S_EXEC0    = 3'd2,
    S_SRC1     = 3'd3,
    S_SRC2     = 3'd4,
    S_EXEC_ALU = 3'd5,
    S_HALT     = 3'd6
  } state_e;

  typedef struct packed {
    logic [2:0] rf_outa;
    logic [2:0] rf_outb;
    logic [2:0] rf_fun;
    logic [3:0] rf_reg;
    logic [3:0] rf_scr;
    logic [4:0] alu_fun;
    logic       alu_wf;
    logic [1:0] arf_outc;
    logic [1:0] arf_outd;
    logic [2:0] arf_fun;
    logic [2:0] arf_reg;
    logic       ir_lh;
    logic       ir_write;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a;
    logic [1:0] mux_b;
    logic       mux_c;
    logic       halted;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    rf_outa: 3'b000, rf_outb: 3'b000, rf_fun: 3'b000, rf_reg: 4'b1111,
    rf_scr: 4'b1111, alu_fun: 5'b00000, alu_wf: 1'b0, arf_outc: 2'b00,
    arf_outd: 2'b00, arf_fun: 3'b000, arf_reg: 3'b111, ir_lh: 1'b0,
    ir_write: 1'b0, mem_wr: 1'b0, mem_cs: 1'b1, mux_a: 2'b00,
    mux_b: 2'b00, mux_c: 1'b0, halted: 1'b0
  };

  // Register-code low bits -> ARF output select: x0x/x01 PC, 10 SP, 11 AR.
  function automatic logic [1:0] arf_code(input logic [1:0] r);
    case (r)
      2'b10:   arf_code = 2'b11;
      2'b11:   arf_code = 2'b10;
      default: arf_code = 2'b00;
    endcase
  endfunction

  function automatic logic [2:0] arf_en(input logic [1:0] r);
    case (r)
      2'b10:   arf_en = 3'b110;
      2'b11:   arf_en = 3'b101;
      default: arf_en = 3'b011;
    endcase
  endfunction

  function automatic logic [3:0] rf_en(input logic [1:0] idx);
    rf_en = ~(4'b1000 >> idx);
  endfunction

  function automatic ctrl_t exec0_ctrl(input logic [5:0] opc, input logic [1:0] rsel,
                                       input logic z);
    ctrl_t c;
    logic  take;
    c    = CTRL_IDLE;
    take = (opc == 6'h00) || (opc == 6'h01 && !z) || (opc == 6'h02 && z);
    if (take) begin
      c.mux_b   = 2'b11;
      c.arf_fun = 3'b100;
      c.arf_reg = 3'b011;
    end
    case (opc)
      6'h20: begin
        c.mux_a  = 2'b11;
        c.rf_fun = 3'b100;
        c.rf_reg = rf_en(rsel);
      end
      6'h21: begin
        c.arf_outd = 2'b10;
        c.mem_cs   = 1'b0;
        c.mux_a    = 2'b10;
        c.rf_fun   = 3'b010;
        c.rf_reg   = rf_en(rsel);
      end
      6'h22: begin
        c.rf_outa  = {1'b0, rsel};
        c.alu_fun  = 5'b10000;
        c.mux_c    = 1'b0;
        c.arf_outd = 2'b10;
        c.mem_cs   = 1'b0;
        c.mem_wr   = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  // Control word for every state whose outputs depend only on captured instruction fields.
  function automatic ctrl_t state_ctrl(input state_e st, input logic [3:0] op,
                                       input logic [2:0] dst, input logic [2:0] s1,
                                       input logic [2:0] s2);
    ctrl_t c;
    c = CTRL_IDLE;
    case (st)
      S_FETCH_L, S_FETCH_H: begin
        c.arf_outd = 2'b00;
        c.mem_cs   = 1'b0;
        c.ir_write = 1'b1;
        c.ir_lh    = (st == S_FETCH_H);
        c.arf_reg  = 3'b011;
        c.arf_fun  = 3'b001;
      end
      S_SRC1, S_SRC2: begin
        c.arf_outc = arf_code((st == S_SRC1) ? s1[1:0] : s2[1:0]);
        c.mux_a    = 2'b01;
        c.rf_fun   = 3'b010;
        c.rf_scr   = (st == S_SRC1) ? 4'b0111 : 4'b1011;
      end
      S_EXEC_ALU: begin
        c.rf_outa = s1[2] ? {1'b0, s1[1:0]} : 3'b100;
        c.rf_outb = s2[2] ? {1'b0, s2[1:0]} : 3'b101;
        c.alu_fun = {1'b1, op};
        c.alu_wf  = 1'b1;
        if (dst[2]) begin
          c.mux_a  = 2'b00;
          c.rf_fun = 3'b010;
          c.rf_reg = rf_en(dst[1:0]);
        end else begin
          c.mux_b   = 2'b00;
          c.arf_fun = 3'b010;
          c.arf_reg = arf_en(dst[1:0]);
        end
      end
      S_HALT:  c.halted = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  state_e     state_q, state_d;
  ctrl_t      out_q, ctrl;
  logic       run_q;
  logic [3:0] op_q, op_d;
  logic [2:0] dst_q, dst_d, s1_q, s1_d, s2_q, s2_d;
  logic       unused_flags;

  assign unused_flags = ^Flags[2:0];

  // Instruction fields come straight from IR in EXEC0 and are held for the ALU tail.
  always_comb begin
    op_d  = op_q;
    dst_d = dst_q;
    s1_d  = s1_q;
    s2_d  = s2_q;
    if (state_q == S_EXEC0) begin
      op_d  = IR_Value[13:10];
      dst_d = IR_Value[8:6];
      s1_d  = IR_Value[5:3];
      s2_d  = IR_Value[2:0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH_L: state_d = S_FETCH_H;
      S_FETCH_H: state_d = S_EXEC0;
      S_EXEC0: begin
        if (IR_Value[15:10] == 6'h3F)      state_d = S_HALT;
        else if (IR_Value[15:14] == 2'b01) state_d = !s1_d[2] ? S_SRC1 :
                                                     !s2_d[2] ? S_SRC2 : S_EXEC_ALU;
        else                               state_d = S_FETCH_L;
      end
      S_SRC1:     state_d = !s2_d[2] ? S_SRC2 : S_EXEC_ALU;
      S_SRC2:     state_d = S_EXEC_ALU;
      S_EXEC_ALU: state_d = S_FETCH_L;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH_L;
    endcase
  end

  // Outputs are registered one edge ahead for the state being entered; the first edge
  // after reset release only arms the FETCH_L control word.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_FETCH_L;
      run_q   <= 1'b0;
      out_q   <= CTRL_IDLE;
      op_q    <= 4'd0;
      dst_q   <= 3'd0;
      s1_q    <= 3'd0;
      s2_q    <= 3'd0;
    end else if (!run_q) begin
      run_q <= 1'b1;
      out_q <= state_ctrl(S_FETCH_L, op_q, dst_q, s1_q, s2_q);
    end else begin
      state_q <= state_d;
      out_q   <= state_ctrl(state_d, op_d, dst_d, s1_d, s2_d);
      op_q    <= op_d;
      dst_q   <= dst_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
    end
  end

  assign ctrl = (state_q == S_EXEC0) ? exec0_ctrl(IR_Value[15:10], IR_Value[9:8], Flags[3])
                                     : out_q;

  assign RF_OutASel  = ctrl.rf_outa;
  assign RF_OutBSel  = ctrl.rf_outb;
  assign RF_FunSel   = ctrl.rf_fun;
  assign RF_RegSel   = ctrl.rf_reg;
  assign RF_ScrSel   = ctrl.rf_scr;
  assign ALU_FunSel  = ctrl.alu_fun;
  assign ALU_WF      = ctrl.alu_wf;
  assign ARF_OutCSel = ctrl.arf_outc;
  assign ARF_OutDSel = ctrl.arf_outd;
  assign ARF_FunSel  = ctrl.arf_fun;
  assign ARF_RegSel  = ctrl.arf_reg;
  assign IR_LH       = ctrl.ir_lh;
  assign IR_Write    = ctrl.ir_write;
  assign Mem_WR      = ctrl.mem_wr;
  assign Mem_CS      = ctrl.mem_cs;
  assign MuxASel     = ctrl.mux_a;
  assign MuxBSel     = ctrl.mux_b;
  assign MuxCSel     = ctrl.mux_c;
  assign Halted      = ctrl.halted;
  assign T           = state_q;

endmodule

// File: tb/tb_hardwired_control_unit.sv
// Directed bench for hardwired_control_unit: table of single-instruction vectors plus
// hand-written ALU, reset-abort, PC-destination and halt sequences.
module tb_hardwired_control_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] IR_Value;
  logic [3:0]  Flags;
  logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel, RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel;
  logic [2:0]  ARF_FunSel, ARF_RegSel;
  logic        IR_LH, IR_Write, Mem_WR, Mem_CS;
  logic [1:0]  MuxASel, MuxBSel;
  logic        MuxCSel;
  logic [2:0]  T;
  logic        Halted;

  hardwired_control_unit dut (
    .Clock(Clock), .Reset(Reset), .IR_Value(IR_Value), .Flags(Flags),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel), .ALU_FunSel(ALU_FunSel),
    .ALU_WF(ALU_WF), .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel),
    .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH),
    .IR_Write(IR_Write), .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel),
    .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .T(T), .Halted(Halted)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [2:0] rf_outa;
    logic [2:0] rf_outb;
    logic [2:0] rf_fun;
    logic [3:0] rf_reg;
    logic [3:0] rf_scr;
    logic [4:0] alu_fun;
    logic       alu_wf;
    logic [1:0] arf_outc;
    logic [1:0] arf_outd;
    logic [2:0] arf_fun;
    logic [2:0] arf_reg;
    logic       ir_lh;
    logic       ir_write;
    logic       mem_wr;
    logic       mem_cs;
    logic [1:0] mux_a;
    logic [1:0] mux_b;
    logic       mux_c;
    logic       halted;
  } ctrl_t;

  typedef struct {
    logic [15:0] ir;
    logic [3:0]  flags;
    int          cycles;
    ctrl_t       exp0;
  } vec_t;

  int    nvec = 0;
  int    nfail = 0;
  ctrl_t idle, fl, fh, e;
  vec_t  vt[14];

  function automatic ctrl_t cur();
    ctrl_t c;
    c.rf_outa = RF_OutASel;  c.rf_outb = RF_OutBSel;  c.rf_fun = RF_FunSel;
    c.rf_reg = RF_RegSel;    c.rf_scr = RF_ScrSel;    c.alu_fun = ALU_FunSel;
    c.alu_wf = ALU_WF;       c.arf_outc = ARF_OutCSel; c.arf_outd = ARF_OutDSel;
    c.arf_fun = ARF_FunSel;  c.arf_reg = ARF_RegSel;  c.ir_lh = IR_LH;
    c.ir_write = IR_Write;   c.mem_wr = Mem_WR;       c.mem_cs = Mem_CS;
    c.mux_a = MuxASel;       c.mux_b = MuxBSel;       c.mux_c = MuxCSel;
    c.halted = Halted;
    return c;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Starts in FETCH_L; runs one instruction and counts cycles until FETCH_L returns.
  task automatic run_vec(input int i);
    int n;
    IR_Value = vt[i].ir;
    Flags    = vt[i].flags;
    chk($sformatf("v%0d T0", i), 64'(T), 64'd0);
    tick();
    chk($sformatf("v%0d T1", i), 64'(T), 64'd1);
    tick();
    chk($sformatf("v%0d T2", i), 64'(T), 64'd2);
    chk($sformatf("v%0d exec0", i), 64'(cur()), 64'(vt[i].exp0));
    n = 3;
    tick();
    while (T != 3'd0 && n < 10) begin
      n++;
      tick();
    end
    chk($sformatf("v%0d cycles", i), 64'(n), 64'(vt[i].cycles));
  endtask

  initial begin
    idle = '0;
    idle.rf_reg = 4'b1111; idle.rf_scr = 4'b1111; idle.arf_reg = 3'b111; idle.mem_cs = 1'b1;
    fl = idle;
    fl.mem_cs = 1'b0; fl.ir_write = 1'b1; fl.arf_reg = 3'b011; fl.arf_fun = 3'b001;
    fh = fl;
    fh.ir_lh = 1'b1;

    for (int i = 0; i < 14; i++) begin
      vt[i].flags = 4'b0000;
      vt[i].cycles = 3;
      vt[i].exp0 = idle;
    end
    vt[0].ir = 16'h8155;                       // LDI R2
    vt[0].exp0.mux_a = 2'b11; vt[0].exp0.rf_fun = 3'b100; vt[0].exp0.rf_reg = 4'b1011;
    vt[1].ir = 16'h8700;                       // LD R4
    vt[1].exp0.arf_outd = 2'b10; vt[1].exp0.mem_cs = 1'b0; vt[1].exp0.mux_a = 2'b10;
    vt[1].exp0.rf_fun = 3'b010; vt[1].exp0.rf_reg = 4'b1110;
    vt[2].ir = 16'h8A00;                       // ST R3
    vt[2].exp0.rf_outa = 3'b010; vt[2].exp0.alu_fun = 5'b10000; vt[2].exp0.arf_outd = 2'b10;
    vt[2].exp0.mem_cs = 1'b0; vt[2].exp0.mem_wr = 1'b1;
    vt[3].ir = 16'h0012;                       // BRA
    vt[4].ir = 16'h0830; vt[4].flags = 4'b1000; // BEQ taken
    vt[5].ir = 16'h0830; vt[5].flags = 4'b0000; // BEQ not taken
    vt[6].ir = 16'h0430; vt[6].flags = 4'b0000; // BNE taken
    vt[7].ir = 16'h0430; vt[7].flags = 4'b1000; // BNE not taken
    vt[8].ir = 16'h0430; vt[8].flags = 4'b0111; // BNE taken, other flags set
    for (int i = 3; i < 9; i++) begin
      if (i != 5 && i != 7) begin
        vt[i].exp0.mux_b = 2'b11; vt[i].exp0.arf_fun = 3'b100; vt[i].exp0.arf_reg = 3'b011;
      end
    end
    vt[9].ir  = 16'h9000;                      // undefined opcode
    vt[10].ir = 16'h4925; vt[10].cycles = 4;   // ALU, no ARF sources
    vt[11].ir = 16'h4172; vt[11].cycles = 5;   // ALU, SRC2 = SP
    vt[12].ir = 16'h4504; vt[12].cycles = 5;   // ALU, SRC1 = PC
    vt[13].ir = 16'h4503; vt[13].cycles = 6;   // ALU, two ARF sources

    Reset = 1'b0; IR_Value = 16'h9000; Flags = 4'b0000;
    tick(); tick();
    chk("reset T", 64'(T), 64'd0);
    chk("reset idle", 64'(cur()), 64'(idle));
    @(negedge Clock) Reset = 1'b1;
    tick();
    chk("fetch_l T", 64'(T), 64'd0);
    chk("fetch_l ctrl", 64'(cur()), 64'(fl));
    tick();
    chk("fetch_h T", 64'(T), 64'd1);
    chk("fetch_h ctrl", 64'(cur()), 64'(fh));
    tick(); tick();

    for (int i = 0; i < 14; i++) run_vec(i);

    // ALU with two ARF sources, then reset while in EXEC_ALU
    IR_Value = 16'h4503;
    tick(); tick();
    chk("alu2 T2", 64'(T), 64'd2);
    tick();
    chk("alu2 T3", 64'(T), 64'd3);
    e = idle; e.arf_outc = 2'b00; e.mux_a = 2'b01; e.rf_fun = 3'b010; e.rf_scr = 4'b0111;
    chk("alu2 src1", 64'(cur()), 64'(e));
    tick();
    chk("alu2 T4", 64'(T), 64'd4);
    e.arf_outc = 2'b10; e.rf_scr = 4'b1011;
    chk("alu2 src2", 64'(cur()), 64'(e));
    tick();
    chk("alu2 T5", 64'(T), 64'd5);
    e = idle; e.rf_outa = 3'b100; e.rf_outb = 3'b101; e.alu_fun = 5'b10001; e.alu_wf = 1'b1;
    e.rf_fun = 3'b010; e.rf_reg = 4'b0111;
    chk("alu2 exec", 64'(cur()), 64'(e));
    #2 Reset = 1'b0;
    #1;
    chk("abort T", 64'(T), 64'd0);
    chk("abort idle", 64'(cur()), 64'(idle));
    tick();
    chk("abort held idle", 64'(cur()), 64'(idle));
    @(negedge Clock) Reset = 1'b1;
    tick();
    chk("release T", 64'(T), 64'd0);
    chk("release fetch", 64'(cur()), 64'(fl));

    // ALU result to PC, followed by a normal fetch
    IR_Value = 16'h4825;
    tick(); tick(); tick();
    chk("dstpc T", 64'(T), 64'd5);
    e = idle; e.rf_outa = 3'b000; e.rf_outb = 3'b001; e.alu_fun = 5'b10010; e.alu_wf = 1'b1;
    e.mux_b = 2'b00; e.arf_fun = 3'b010; e.arf_reg = 3'b011;
    chk("dstpc exec", 64'(cur()), 64'(e));
    tick();
    chk("dstpc next fetch", 64'(cur()), 64'(fl));

    // HLT holds until reset
    IR_Value = 16'hFC00;
    tick(); tick();
    chk("hlt exec0 idle", 64'(cur()), 64'(idle));
    for (int k = 0; k < 10; k++) begin
      tick();
      chk($sformatf("hlt T c%0d", k), 64'(T), 64'd6);
      chk($sformatf("hlt Halted c%0d", k), 64'(Halted), 64'd1);
    end
    #2 Reset = 1'b0;
    #1;
    chk("hlt reset T", 64'(T), 64'd0);
    chk("hlt reset Halted", 64'(Halted), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
